// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: circular queue between the PC/instruction memory and IF/ID.
// Define FETCH_BUF_BYPASS_EN to present a response to IF/ID in the same cycle it returns.
module fetch_buffer #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        flush,
    input  logic        stall,
    output logic        pc_stall,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
    localparam logic [31:0] NOP = 32'h00000013;

    logic [31:0]      pc_q   [DEPTH];
    logic [31:0]      inst_q [DEPTH];
    logic [DEPTH-1:0] filled_q;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] fill_idx;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] num_filled;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] flush_sum;
    logic [CNT_W-1:0] flush_drop;
    logic             accept;
    logic             fill;
    logic             pop;
    logic             head_valid;
    logic             bypass_hit;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign imem_req_valid = !reset && !flush && (count < FULL) && (drop_cnt == '0);
    assign accept         = imem_req_valid && imem_req_ready;
    assign pc_stall       = reset ? 1'b1 : (flush ? 1'b0 : !accept);
    assign imem_addr      = pc;

    // Entries fill in request order, so the filled ones always form a run starting at head.
    assign fill_idx = head + num_filled[PTR_W-1:0];
    assign fill     = !reset && !flush && imem_resp_valid && (drop_cnt == '0)
                      && (num_filled != count);

`ifdef FETCH_BUF_BYPASS_EN
    assign bypass_hit = fill && (num_filled == '0);
`else
    assign bypass_hit = 1'b0;
`endif

    assign head_valid = !reset && (filled_q[head] || bypass_hit);
    assign id_valid   = head_valid;
    assign id_pc      = head_valid ? pc_q[head] : 32'h0;
    assign id_inst    = !head_valid ? NOP : (bypass_hit ? imem_resp_data : inst_q[head]);
    assign pop        = head_valid && !stall && !flush;

    // Responses still owed for allocated-but-unfilled entries must be thrown away after a redirect.
    assign flush_sum  = drop_cnt + (count - num_filled);
    assign flush_drop = (imem_resp_valid && (flush_sum != '0)) ? flush_sum - CNT_W'(1) : flush_sum;

    always_ff @(posedge clk) begin
        if (reset) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            num_filled <= '0;
            drop_cnt   <= '0;
            filled_q   <= '0;
        end else if (flush) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            num_filled <= '0;
            filled_q   <= '0;
            drop_cnt   <= flush_drop;
        end else begin
            if (accept) begin
                pc_q[tail]     <= pc;
                filled_q[tail] <= 1'b0;
                tail           <= next_ptr(tail);
            end
            if (fill) begin
                inst_q[fill_idx]   <= imem_resp_data;
                filled_q[fill_idx] <= 1'b1;
            end
            // Pop comes last so a bypassed entry written and consumed together ends up empty.
            if (pop) begin
                filled_q[head] <= 1'b0;
                head           <= next_ptr(head);
            end
            if (imem_resp_valid && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - CNT_W'(1);
            end
            count      <= count + CNT_W'(accept) - CNT_W'(pop);
            num_filled <= num_filled + CNT_W'(fill) - CNT_W'(pop);
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: directed scenarios plus random traffic against a queue model.
// Honours FETCH_BUF_BYPASS_EN the same way as the design.
module tb_fetch_buffer;

    localparam int DEPTH = 2;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc = 32'h0;
    logic        flush = 1'b0;
    logic        stall = 1'b0;
    logic        pc_stall;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'h0;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;

    fetch_buffer #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .pc             (pc),
        .flush          (flush),
        .stall          (stall),
        .pc_stall       (pc_stall),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_inst        (id_inst)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        bit          filled;
    } ent_t;

    typedef struct {
        logic [31:0] data;
        int          due;
    } mem_t;

    ent_t        mq[$];
    mem_t        pend[$];
    int          drop = 0;
    int          cyc = 0;
    int          req_seq = 0;
    int          lat_max = 0;
    int          checks = 0;
    int          fails = 0;
    logic [31:0] pc_reg = 32'h0;
    logic [31:0] cur_target = 32'h0;
    bit          cur_reset, cur_flush, e_acc, e_stall, e_pop;
    int          fidx;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] addr, input int seq);
        if (addr == 32'h0) return 32'h00500093;
        return {seq[15:0], addr[15:0]};
    endfunction

    // Drive one cycle of inputs, then compare every output against the queue model.
    task automatic applyStimulus(input bit r, input bit f, input bit s, input bit rdy,
                                 input bit resp_en, input logic [31:0] target);
        bit          head_ok;
        bit          e_req;
        bit          e_idv;
        logic [31:0] head_inst;
        @(negedge clk);
        reset          = r;
        flush          = f;
        stall          = s;
        imem_req_ready = rdy;
        pc             = pc_reg;
        cur_target     = target;
        cur_reset      = r;
        cur_flush      = f;
        if (!r && resp_en && pend.size() > 0 && pend[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = pend[0].data;
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
        end
        #1;
        e_req   = !r && !f && (mq.size() < DEPTH) && (drop == 0);
        e_acc   = e_req && rdy;
        e_stall = r ? 1'b1 : (f ? 1'b0 : !e_acc);
        fidx    = -1;
        if (!r && !f && imem_resp_valid && drop == 0) begin
            for (int i = 0; i < mq.size(); i++) begin
                if (fidx < 0 && !mq[i].filled) fidx = i;
            end
        end
        head_ok   = (mq.size() > 0) && mq[0].filled;
        head_inst = (mq.size() > 0) ? mq[0].inst : 32'h0;
`ifdef FETCH_BUF_BYPASS_EN
        if (fidx == 0) begin
            head_ok   = 1'b1;
            head_inst = imem_resp_data;
        end
`endif
        e_idv = !r && head_ok;
        e_pop = e_idv && !s && !f;
        checkOutput("imem_req_valid", 32'(imem_req_valid), 32'(e_req));
        checkOutput("pc_stall", 32'(pc_stall), 32'(e_stall));
        checkOutput("imem_addr", imem_addr, pc_reg);
        checkOutput("id_valid", 32'(id_valid), 32'(e_idv));
        checkOutput("id_pc", id_pc, e_idv ? mq[0].pc : 32'h0);
        checkOutput("id_inst", id_inst, e_idv ? head_inst : NOP);
    endtask

    // Advance the model, PC register and memory model as the clock edge will.
    task automatic commit_cycle();
        ent_t e;
        int   unf;
        if (cur_reset) begin
            mq.delete();
            pend.delete();
            drop   = 0;
            pc_reg = 32'h0;
        end else begin
            if (imem_resp_valid) void'(pend.pop_front());
            if (cur_flush) begin
                unf = 0;
                foreach (mq[i]) if (!mq[i].filled) unf++;
                unf = unf + drop;
                if (imem_resp_valid && unf > 0) unf--;
                drop = unf;
                mq.delete();
                pc_reg = cur_target;
            end else begin
                if (imem_resp_valid) begin
                    if (drop > 0) begin
                        drop--;
                    end else if (fidx >= 0) begin
                        e        = mq[fidx];
                        e.filled = 1'b1;
                        e.inst   = imem_resp_data;
                        mq[fidx] = e;
                    end
                end
                if (e_pop) void'(mq.pop_front());
                if (e_acc) begin
                    e.pc     = pc_reg;
                    e.inst   = 32'h0;
                    e.filled = 1'b0;
                    mq.push_back(e);
                    pend.push_back('{data: mem_word(pc_reg, req_seq),
                                     due: cyc + 1 + $urandom_range(0, lat_max)});
                    req_seq++;
                end
                if (!e_stall) pc_reg = pc_reg + 32'd4;
            end
        end
        cyc++;
    endtask

    task automatic run_cycle(input bit r, input bit f, input bit s, input bit rdy,
                             input bit resp_en, input logic [31:0] target);
        applyStimulus(r, f, s, rdy, resp_en, target);
        commit_cycle();
    endtask

    task automatic do_reset();
        run_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        run_cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h80);
    endtask

    // Run until the first instruction is presented and check its address.
    task automatic expect_first_pc(input string tag, input logic [31:0] exp_pc);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
            if (id_valid) begin
                seen = 1'b1;
                checkOutput(tag, id_pc, exp_pc);
            end
            commit_cycle();
        end
        checkOutput({tag, "_seen"}, 32'(seen), 32'h1);
    endtask

    initial begin
        int          n_acc;
        logic [31:0] acc_pc[2];
        logic [31:0] held_addr;

        // Reset state and the cycle after reset.
        do_reset();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("post_reset_req_valid", 32'(imem_req_valid), 32'h1);
        checkOutput("post_reset_id_valid", 32'(id_valid), 32'h0);
        commit_cycle();

        // First fetch from pc 0 with a one-cycle memory.
        do_reset();
        run_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
`ifdef FETCH_BUF_BYPASS_EN
        checkOutput("first_fetch_valid", 32'(id_valid), 32'h1);
        checkOutput("first_fetch_inst", id_inst, 32'h00500093);
        checkOutput("first_fetch_pc", id_pc, 32'h0);
`endif
        commit_cycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
`ifndef FETCH_BUF_BYPASS_EN
        checkOutput("first_fetch_valid", 32'(id_valid), 32'h1);
        checkOutput("first_fetch_inst", id_inst, 32'h00500093);
        checkOutput("first_fetch_pc", id_pc, 32'h0);
`endif
        commit_cycle();

        // Decode stalled for 5 cycles: only DEPTH requests get in.
        do_reset();
        n_acc = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0);
            if (imem_req_valid && imem_req_ready) begin
                if (n_acc < 2) acc_pc[n_acc] = imem_addr;
                n_acc++;
            end
            if (i >= 2) begin
                checkOutput("stall_pc_stall", 32'(pc_stall), 32'h1);
                checkOutput("stall_req_valid", 32'(imem_req_valid), 32'h0);
            end
            commit_cycle();
        end
        checkOutput("stall_accept_count", 32'(n_acc), 32'd2);
        checkOutput("stall_accept_pc0", acc_pc[0], 32'h0);
        checkOutput("stall_accept_pc1", acc_pc[1], 32'h4);
        for (int i = 0; i < 4; i++) run_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);

        // Flush with two requests outstanding: both responses are dropped.
        do_reset();
        run_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        run_cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h100);
        expect_first_pc("flush_first_pc", 32'h100);

        // Flush coinciding with the only outstanding response.
        do_reset();
        run_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h200);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        checkOutput("flush_resp_req_valid", 32'(imem_req_valid), 32'h1);
        checkOutput("flush_resp_drop_cnt", 32'(dut.drop_cnt), 32'h0);
        commit_cycle();
        expect_first_pc("flush_resp_first_pc", 32'h200);

        // Memory not ready for 3 cycles: PC and address hold.
        run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h340);
        for (int i = 0; i < 6; i++) run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        held_addr = pc_reg;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
            checkOutput("not_ready_pc_stall", 32'(pc_stall), 32'h1);
            checkOutput("not_ready_addr", imem_addr, held_addr);
            commit_cycle();
        end
        checkOutput("not_ready_held_340", held_addr, 32'h340);

        // Reset with a full queue.
        do_reset();
        for (int i = 0; i < 5; i++) run_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0);
        run_cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("full_reset_id_valid", 32'(id_valid), 32'h0);
        checkOutput("full_reset_count", 32'(dut.count), 32'h0);
        commit_cycle();

        // Random traffic with variable memory latency.
        lat_max = 3;
        for (int i = 0; i < 3000; i++) begin
            run_cycle($urandom_range(0, 99) == 0, $urandom_range(0, 15) == 0,
                      $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0,
                      $urandom_range(0, 3) != 0, 32'($urandom_range(0, 4095)) << 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
